fp_adder_arbiter: RTL and testbench

- Round-robin arbiter that shares the single non-pipelined 16-bit float adder (input_a/input_b/adder_input_STB/adder_BUSY in, output_sum/adder_output_STB/output_module_BUSY out) among N_REQ requesters.
- Only one operation is in flight at a time. Each result is routed back to the requester that issued it over a per-requester STB/BUSY handshake.
- Sits between the co-processor command decoders and the adder instance. The adder's clk/rst are tied to this block's clk/rst.

---
 rtl/fp_adder_arbiter.sv | 124 ++++++++++++
 tb/tb_fp_adder_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that time-shares one non-pipelined float adder among N_REQ requesters.
// One operation is in flight at a time; the result goes back to the requester that issued it.
//
// state   | meaning
// IDLE    | waiting for any requester; a grant is made on the first edge with a request
// ISSUE   | operands presented to the adder with adder_stb=1 until the adder accepts them
// WAIT    | adder computing; adder_out_busy=0 until the adder presents its result
// DELIVER | result held on rsp_stb[owner_id]/rsp_sum until the owner takes it
module fp_adder_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_stb,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_busy,
  output logic [N_REQ-1:0]        rsp_stb,
  output logic [DATA_W-1:0]       rsp_sum,
  input  logic [N_REQ-1:0]        rsp_busy,
  output logic [DATA_W-1:0]       adder_a,
  output logic [DATA_W-1:0]       adder_b,
  output logic                    adder_stb,
  input  logic                    adder_busy,
  input  logic [DATA_W-1:0]       adder_sum,
  input  logic                    adder_out_stb,
  output logic                    adder_out_busy,
  output logic [ID_W-1:0]         owner_id,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            any_req;

  // Scan from the farthest slot to the nearest so the nearest requester after last_grant wins.
  always_comb begin
    winner  = last_grant;
    any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % N_REQ;
      if (req_stb[idx]) begin
        winner  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_busy[i] = !(state == IDLE && req_stb[i] && winner == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)               state_next = ISSUE;
      ISSUE:   if (!adder_busy)           state_next = WAIT;
      WAIT:    if (adder_out_stb)         state_next = DELIVER;
      DELIVER: if (!rsp_busy[owner_id])   state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adder_a        <= '0;
      adder_b        <= '0;
      adder_stb      <= 1'b0;
      adder_out_busy <= 1'b1;
      rsp_stb        <= '0;
      rsp_sum        <= '0;
      owner_id       <= '0;
      op_count       <= '0;
      last_grant     <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            adder_a   <= req_a[int'(winner)*DATA_W +: DATA_W];
            adder_b   <= req_b[int'(winner)*DATA_W +: DATA_W];
            owner_id  <= winner;
            adder_stb <= 1'b1;
          end
        end
        ISSUE: begin
          if (!adder_busy) begin
            adder_stb      <= 1'b0;
            adder_out_busy <= 1'b0;
          end
        end
        WAIT: begin
          if (adder_out_stb) begin
            rsp_sum        <= adder_sum;
            adder_out_busy <= 1'b1;
            rsp_stb        <= N_REQ'(1) << owner_id;
          end
        end
        DELIVER: begin
          // The pointer moves only here, so a stalled delivery holds off every new grant.
          if (!rsp_busy[owner_id]) begin
            rsp_stb    <= '0;
            last_grant <= owner_id;
            op_count   <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter with a behavioural bfloat16 adder and
// a transaction-level round-robin reference model.
module tb_fp_adder_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_stb;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_busy, rsp_stb, rsp_busy;
  logic [W-1:0]   rsp_sum, adder_a, adder_b, adder_sum;
  logic           adder_stb, adder_busy, adder_out_stb, adder_out_busy;
  logic [1:0]     owner_id;
  logic [15:0]    op_count;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req_stb(req_stb), .req_a(req_a), .req_b(req_b),
    .req_busy(req_busy), .rsp_stb(rsp_stb), .rsp_sum(rsp_sum), .rsp_busy(rsp_busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_stb(adder_stb), .adder_busy(adder_busy),
    .adder_sum(adder_sum), .adder_out_stb(adder_out_stb), .adder_out_busy(adder_out_busy),
    .owner_id(owner_id), .op_count(op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // bfloat16 helpers via double precision; normals and zero only, truncating result
  function automatic real bf2r(logic [15:0] x);
    if (x[14:7] == 8'd0) return 0.0;
    return $bitstoreal({x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'b0});
  endfunction

  function automatic logic [15:0] bf_add(logic [15:0] a, logic [15:0] b);
    real s;
    logic [63:0] d;
    s = bf2r(a) + bf2r(b);
    if (s == 0.0) return 16'h0000;
    d = $realtobits(s);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:45]};
  endfunction

  function automatic logic [15:0] rnd_bf();
    return {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  function automatic int rr_winner(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  typedef enum {P_IDLE, P_ISSUE, P_WAIT, P_DELIVER} phase_t;
  phase_t      phase;
  int          ptr, owner_m;
  logic [15:0] ops_m;
  logic [47:0] cmd_q[N][$];
  logic [15:0] exp_q[N][$];
  int          del_log[$];
  bit          rnd_rsp_busy = 0;

  task automatic push_cmd(int i, logic [15:0] a, logic [15:0] b, logic [15:0] e);
    cmd_q[i].push_back({a, b, e});
  endtask

  task automatic reset_begin();
    rst = 1'b1;
    req_stb = '0;
    for (int i = 0; i < N; i++) begin
      cmd_q[i].delete();
      exp_q[i].delete();
    end
    del_log.delete();
    phase = P_IDLE; ptr = N - 1; owner_m = 0; ops_m = 16'd0;
  endtask

  task automatic reset_end();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_adder_stb", adder_stb, 0);
    chk("rst_adder_out_busy", adder_out_busy, 1);
    chk("rst_rsp_stb", rsp_stb, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_adder_ab", {adder_a, adder_b}, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_req_busy", req_busy, 4'hF);
  endtask

  task automatic wait_idle(int budget, string name);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (phase == P_IDLE) && (req_stb == '0);
      for (int i = 0; i < N; i++)
        if (cmd_q[i].size() != 0 || exp_q[i].size() != 0) done = 0;
    end
    chk({name, "_timeout"}, done, 1);
  endtask

  // Behavioural non-pipelined adder with variable compute time and post-op busy cooldown
  initial begin
    int ast, cnt;
    logic [15:0] res;
    ast = 0; cnt = 0; res = 16'h0;
    adder_busy = 1'b0; adder_out_stb = 1'b0; adder_sum = 16'h0;
    forever begin
      @(posedge clk);
      if (rst) ast = 0;
      else case (ast)
        0: if (adder_stb && !adder_busy) begin
             res = bf_add(adder_a, adder_b); cnt = $urandom_range(1, 4); ast = 1;
           end
        1: begin cnt--; if (cnt == 0) ast = 2; end
        2: if (adder_out_stb && !adder_out_busy) begin cnt = $urandom_range(0, 2); ast = 3; end
        default: if (cnt == 0) ast = 0; else cnt--;
      endcase
      #1;
      adder_busy    = (ast != 0);
      adder_out_stb = (ast == 2);
      adder_sum     = (ast == 2) ? res : 16'($urandom);
    end
  end

  // Requesters: hold STB and data until accepted, then take the next queued command
  initial begin
    logic [N-1:0] acc;
    logic [47:0]  c;
    req_stb = '0; req_a = '0; req_b = '0;
    forever begin
      @(posedge clk);
      acc = rst ? '0 : (req_stb & ~req_busy);
      #1;
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (acc[i]) req_stb[i] = 1'b0;
          if (!req_stb[i] && cmd_q[i].size() > 0) begin
            c = cmd_q[i].pop_front();
            req_a[i*W +: W] = c[47:32];
            req_b[i*W +: W] = c[31:16];
            exp_q[i].push_back(c[15:0]);
            req_stb[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rsp_busy = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rsp_busy) rsp_busy = N'($urandom);
    end
  end

  // Monitor: compares pre-edge outputs with the transaction model, then advances the model
  initial begin
    int win;
    logic [N-1:0] exp_rb;
    forever begin
      @(posedge clk);
      if (!rst) begin
        win = rr_winner(req_stb, ptr);
        for (int i = 0; i < N; i++) exp_rb[i] = !(phase == P_IDLE && req_stb[i] && win == i);
        chk("req_busy", req_busy, exp_rb);
        chk("adder_stb", adder_stb, phase == P_ISSUE);
        chk("adder_out_busy", adder_out_busy, phase != P_WAIT);
        chk("rsp_stb", rsp_stb, (phase == P_DELIVER) ? (N'(1) << owner_m) : '0);
        chk("op_count", op_count, ops_m);
        chk("owner_id", owner_id, owner_m);
        case (phase)
          P_IDLE:  if (win >= 0) begin owner_m = win; phase = P_ISSUE; end
          P_ISSUE: if (!adder_busy) phase = P_WAIT;
          P_WAIT:  if (adder_out_stb) phase = P_DELIVER;
          default: begin
            if (exp_q[owner_m].size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_sum", rsp_sum, exp_q[owner_m][0]);
            if (!rsp_busy[owner_m]) begin
              if (exp_q[owner_m].size() > 0) void'(exp_q[owner_m].pop_front());
              del_log.push_back(owner_m);
              ptr = owner_m; ops_m = ops_m + 16'd1; phase = P_IDLE;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    bit seen;
    int ord[6];
    ord = '{0, 1, 2, 3, 0, 1};
    reset_begin();
    reset_end();
    chk_reset_vals();

    // single requester
    push_cmd(0, 16'h3F80, 16'h3F80, 16'h4000);
    wait_idle(200, "t1");
    chk("t1_op_count", op_count, 1);
    chk("t1_log_size", del_log.size(), 1);
    if (del_log.size() == 1) chk("t1_owner", del_log[0], 0);

    // simultaneous 0 and 2 from reset pointer
    reset_begin(); reset_end();
    push_cmd(0, 16'h4040, 16'hBF80, 16'h4000);
    push_cmd(2, 16'h4040, 16'hBF80, 16'h4000);
    wait_idle(200, "t2");
    chk("t2_log_size", del_log.size(), 2);
    if (del_log.size() == 2) begin
      chk("t2_first", del_log[0], 0);
      chk("t2_second", del_log[1], 2);
    end

    // all four continuously
    reset_begin(); reset_end();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_cmd(i, 16'h3F80, 16'h4000, 16'h4040);
    wait_idle(400, "t3");
    chk("t3_log_size", del_log.size(), 8);
    if (del_log.size() >= 6)
      for (int k = 0; k < 6; k++) chk($sformatf("t3_order%0d", k), del_log[k], ord[k]);

    // stalled delivery to requester 1, then next grant to 2 immediately after
    @(negedge clk);
    rsp_busy = 4'b0010;
    push_cmd(1, 16'h3F80, 16'h3F80, 16'h4000);
    push_cmd(2, 16'h4040, 16'hBF80, 16'h4000);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_stb[1];
    end
    chk("t4_reach_deliver", seen, 1);
    held = rsp_sum;
    chk("t4_sum", held, 16'h4000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_hold_stb", rsp_stb, 4'b0010);
      chk("t4_hold_sum", rsp_sum, held);
      chk("t4_req_busy", req_busy, 4'hF);
      chk("t4_adder_stb", adder_stb, 0);
    end
    rsp_busy = '0;
    @(posedge clk); #1;
    chk("t4_released", rsp_stb, 0);
    chk("t4_grant_ready", req_busy, 4'b1011);
    @(posedge clk); #1;
    chk("t4_next_issue", adder_stb, 1);
    chk("t4_next_owner", owner_id, 2);
    wait_idle(200, "t4");

    // asynchronous reset while the adder is computing
    push_cmd(3, 16'h4040, 16'h4040, 16'h40C0);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (phase == P_WAIT);
    end
    chk("t5_reach_wait", seen, 1);
    reset_begin();
    #1;
    chk_reset_vals();
    reset_end();
    push_cmd(3, 16'h3F80, 16'h3F80, 16'h4000);
    wait_idle(200, "t5");
    chk("t5_log_size", del_log.size(), 1);
    if (del_log.size() == 1) chk("t5_owner", del_log[0], 3);

    // randomized traffic with random result back-pressure
    rnd_rsp_busy = 1;
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a, b;
      @(negedge clk);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      a = rnd_bf(); b = rnd_bf();
      push_cmd($urandom_range(0, N - 1), a, b, bf_add(a, b));
    end
    wait_idle(6000, "rand");
    rnd_rsp_busy = 0;
    @(negedge clk);
    rsp_busy = '0;
    chk("rand_op_count", op_count, 16'd61);

    // op_count wrap
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    ops_m = 16'hFFFF;
    #1;
    release dut.op_count;
    @(negedge clk);
    chk("wrap_preload", op_count, 16'hFFFF);
    push_cmd(0, 16'h3F80, 16'h3F80, 16'h4000);
    wait_idle(200, "wrap");
    chk("wrap_op_count", op_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
